// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg
// Shared definitions for the keypad scanner and the display drivers:
// matrix geometry, column rotation seed, key FSM state encoding and
// small helpers for classifying a 16-bit key snapshot.
package keypad_scan_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam int KP_KEYS = KP_ROWS * KP_COLS;

    // Active-low one-cold pattern loaded at reset; column 0 driven first.
    localparam logic [KP_COLS-1:0] COL_SEED_NEG = 4'b1110;

    typedef enum logic [1:0] {
        KEY_IDLE  = 2'd0,   // stable snapshot empty
        KEY_HELD  = 2'd1,   // exactly one key stable
        KEY_MULTI = 2'd2    // two or more keys stable
    } key_state_e;

    // True when exactly one bit of the snapshot is set.
    function automatic logic key_single(input logic [KP_KEYS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Index of the highest set bit; only meaningful for a single-key snapshot.
    function automatic logic [3:0] key_code(input logic [KP_KEYS-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < KP_KEYS; i++)
            if (v[i]) c = 4'(i);
        return c;
    endfunction

endpackage

// File: rtl/keypad_scan_strobe.sv
// scan_strobe
// Dwell counter plus one-cold selector rotator. The selector holds each
// position for SCAN_CYCLES clocks; o_tick marks the last cycle of a dwell,
// and the selector rotates left on that edge. Shared with the display mux.
//   i_clk, i_rst_n : clock, async active-low reset
//   o_tick         : terminal count of the dwell counter
//   o_sel_neg      : active-low one-cold select (position o_idx low)
//   o_idx          : index of the currently selected position
module scan_strobe
    import keypad_scan_pkg::*;
#(
    parameter int                 SCAN_CYCLES = 27000,
    parameter int                 WIDTH       = KP_COLS,
    parameter logic [WIDTH-1:0]   SEED_NEG    = WIDTH'(COL_SEED_NEG),
    localparam int                IW          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_tick,
    output logic [WIDTH-1:0] o_sel_neg,
    output logic [IW-1:0]    o_idx
);

    localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sel_q, sel_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             tick;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        sel_d = sel_q;
        idx_d = idx_q;
        if (tick) begin
            sel_d = {sel_q[WIDTH-2:0], sel_q[WIDTH-1]};
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            sel_q <= SEED_NEG;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            idx_q <= idx_d;
        end
    end

    assign o_tick    = tick;
    assign o_sel_neg = sel_q;
    assign o_idx     = idx_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
// 4x4 matrix keypad scanner with frame-level debounce and a single-entry
// key event output with valid/ready handshake.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_rows_neg     : raw row lines (active-low, asynchronous)
//   o_cols_neg     : column drive, one-cold active-low
//   o_key, o_valid : pending key event (code = row*4+col)
//   i_ready        : consumer accept
//   o_overrun      : one-cycle pulse when an event is dropped
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_CYCLES     = 27000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [KP_ROWS-1:0]  i_rows_neg,
    output logic [KP_COLS-1:0]  o_cols_neg,
    output logic [3:0]          o_key,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_overrun
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);

    // Row synchronizer; idles at all-ones (no key) out of reset.
    logic [KP_ROWS-1:0] sync1_q, sync2_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= i_rows_neg;
            sync2_q <= sync1_q;
        end
    end

    logic       tick;
    logic [1:0] col_idx;

    scan_strobe #(
        .SCAN_CYCLES (SCAN_CYCLES),
        .WIDTH       (KP_COLS),
        .SEED_NEG    (COL_SEED_NEG)
    ) u_strobe (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .o_tick    (tick),
        .o_sel_neg (o_cols_neg),
        .o_idx     (col_idx)
    );

    logic [KP_KEYS-1:0] frame_q, frame_d;
    logic [KP_KEYS-1:0] prev_q, prev_d;
    logic [KP_KEYS-1:0] stable_q, stable_d;
    logic [3:0]         match_q, match_d;
    logic               frame_done, stable_upd;

    key_state_e state_q, state_d;
    logic       key_event;
    logic [3:0] event_code;

    logic       valid_q, valid_d;
    logic [3:0] key_q, key_d;
    logic       ovr_q, ovr_d;
    logic       accept;

    assign frame_done = tick && (col_idx == 2'(KP_COLS - 1));

    // Capture + debounce. frame_d already contains the column being sampled,
    // so on the completing tick it is the full new frame.
    always_comb begin
        frame_d    = frame_q;
        prev_d     = prev_q;
        match_d    = match_q;
        stable_d   = stable_q;
        stable_upd = 1'b0;
        if (tick) begin
            for (int r = 0; r < KP_ROWS; r++)
                for (int c = 0; c < KP_COLS; c++)
                    if (col_idx == 2'(c))
                        frame_d[r*KP_COLS + c] = ~sync2_q[r];
        end
        if (frame_done) begin
            if (frame_d == prev_q)
                match_d = (match_q >= DEB) ? DEB : match_q + 4'd1;
            else
                match_d = 4'd1;
            prev_d = frame_d;
            if (match_d == DEB) begin
                stable_upd = 1'b1;
                stable_d   = frame_d;
            end
        end
    end

    // Key FSM: an event only on the way out of IDLE into a single key, so
    // a full release is needed between events.
    always_comb begin
        state_d    = state_q;
        key_event  = 1'b0;
        event_code = key_code(stable_d);
        if (stable_upd) begin
            if (stable_d == '0)
                state_d = KEY_IDLE;
            else if (key_single(stable_d)) begin
                state_d   = KEY_HELD;
                key_event = (state_q == KEY_IDLE);
            end else
                state_d = KEY_MULTI;
        end
    end

    // Single-entry event register; a new event may replace one being
    // accepted in the same cycle, otherwise it is dropped.
    always_comb begin
        accept  = valid_q && i_ready;
        valid_d = valid_q;
        key_d   = key_q;
        ovr_d   = 1'b0;
        if (key_event) begin
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                key_d   = event_code;
            end else
                ovr_d = 1'b1;
        end else if (accept)
            valid_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_q  <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            match_q  <= '0;
            state_q  <= KEY_IDLE;
            valid_q  <= 1'b0;
            key_q    <= '0;
            ovr_q    <= 1'b0;
        end else begin
            frame_q  <= frame_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            match_q  <= match_d;
            state_q  <= state_d;
            valid_q  <= valid_d;
            key_q    <= key_d;
            ovr_q    <= ovr_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_key     = key_q;
    assign o_overrun = ovr_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
// Randomized bench: a behavioural keypad drives the rows from the column
// drive, and a frame-level reference (last N frames identical, release
// re-arms the next event) predicts the event stream cycle by cycle.
module tb_keypad_scan;

    localparam int SC    = 4;
    localparam int DF    = 2;
    localparam int FRAME = SC * 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [3:0]  i_rows_neg;
    logic [3:0]  o_cols_neg;
    logic [3:0]  o_key;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic        o_overrun;
    logic [15:0] pressed = '0;

    always #5 i_clk = ~i_clk;

    // Physical keypad: a row reads low when a pressed key joins it to the
    // column currently driven low.
    always_comb begin
        i_rows_neg = '1;
        for (int r = 0; r < 4; r++)
            i_rows_neg[r] = ~|(pressed[r*4 +: 4] & ~o_cols_neg);
    end

    keypad_scan #(.SCAN_CYCLES(SC), .DEBOUNCE_FRAMES(DF)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rows_neg (i_rows_neg),
        .o_cols_neg (o_cols_neg),
        .o_key      (o_key),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_overrun  (o_overrun)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference state
    int          k;
    logic [15:0] hist[$];
    bit          armed;
    bit          mv, mo;
    logic [3:0]  mk;
    int          acc_cnt, ovr_cnt;

    task automatic model_reset();
        k = 0;
        hist.delete();
        armed = 1'b1;
        mv = 1'b0;
        mo = 1'b0;
        mk = '0;
    endtask

    task automatic model_frame(input logic [15:0] f, output bit ev, output logic [3:0] code);
        bit same;
        ev = 1'b0;
        code = '0;
        hist.push_back(f);
        if (hist.size() > DF) void'(hist.pop_front());
        same = (hist.size() == DF);
        foreach (hist[i]) if (hist[i] != f) same = 1'b0;
        if (same) begin
            if (f == 16'h0)
                armed = 1'b1;
            else begin
                if ($countones(f) == 1 && armed) begin
                    ev = 1'b1;
                    for (int i = 0; i < 16; i++) if (f[i]) code = 4'(i);
                end
                armed = 1'b0;
            end
        end
    endtask

    task automatic step(input bit rdy);
        bit         ev, acc;
        logic [3:0] code, ec;
        i_ready = rdy;
        if (o_valid && rdy) acc_cnt++;
        @(posedge i_clk);
        k++;
        ev = 1'b0;
        code = '0;
        if (k % FRAME == 0) model_frame(pressed, ev, code);
        acc = mv && rdy;
        mo = 1'b0;
        if (ev) begin
            if (!mv || acc) begin
                mv = 1'b1;
                mk = code;
            end else
                mo = 1'b1;
        end else if (acc)
            mv = 1'b0;
        #1;
        if (o_overrun) ovr_cnt++;
        ec = ~(4'b0001 << ((k / SC) % 4));
        chk("valid", 32'(o_valid), 32'(mv));
        chk("key", 32'(o_key), 32'(mk));
        chk("overrun", 32'(o_overrun), 32'(mo));
        chk("cols", 32'(o_cols_neg), 32'(ec));
    endtask

    // mode 0: ready low, 1: ready high, 2: random ready
    task automatic run_frames(input logic [15:0] mask, input int n, input int mode);
        pressed = mask;
        repeat (n * FRAME) step(mode == 2 ? bit'($urandom_range(1)) : bit'(mode));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_key"}, 32'(o_key), 32'd0);
        chk({tag, "_ovr"}, 32'(o_overrun), 32'd0);
        chk({tag, "_cols"}, 32'(o_cols_neg), 32'hE);
    endtask

    initial begin
        logic [15:0] m;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs("rst0");
        i_rst_n = 1'b1;

        // idle scan, no keys
        acc_cnt = 0;
        run_frames(16'h0, 3, 2);
        chk("idle_events", 32'(acc_cnt), 32'd0);

        // key 9 held, then released
        acc_cnt = 0;
        run_frames(16'h1 << 9, 4, 1);
        run_frames(16'h0, 3, 1);
        chk("held9_events", 32'(acc_cnt), 32'd1);

        // key 6 bounces across frames, then settles
        acc_cnt = 0;
        run_frames(16'h1 << 6, 1, 1);
        run_frames(16'h0, 1, 1);
        run_frames(16'h1 << 6, 1, 1);
        run_frames(16'h1 << 6, 3, 1);
        run_frames(16'h0, 3, 1);
        chk("bounce_events", 32'(acc_cnt), 32'd1);

        // overrun with consumer stalled
        ovr_cnt = 0;
        run_frames(16'h1, 3, 0);
        run_frames(16'h0, 3, 0);
        run_frames(16'h1 << 5, 3, 0);
        run_frames(16'h0, 2, 0);
        chk("stall_key", 32'(o_key), 32'd0);
        run_frames(16'h0, 1, 1);
        chk("ovr_pulses", 32'(ovr_cnt), 32'd1);

        // multi-key then partial release: no event until full release
        acc_cnt = 0;
        run_frames((16'h1 << 3) | (16'h1 << 12), 3, 1);
        run_frames(16'h1 << 3, 3, 1);
        chk("multi_events", 32'(acc_cnt), 32'd0);
        run_frames(16'h0, 3, 1);
        run_frames(16'h1 << 12, 3, 1);
        run_frames(16'h0, 2, 1);
        chk("rearm_events", 32'(acc_cnt), 32'd1);

        // random key traffic
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(3))
                0:       m = 16'h0;
                1, 2:    m = 16'h1 << $urandom_range(15);
                default: m = (16'h1 << $urandom_range(15)) | (16'h1 << $urandom_range(15));
            endcase
            run_frames(m, $urandom_range(4, 1), 2);
        end

        // reset mid-frame with an event pending
        run_frames(16'h0, 2, 1);
        run_frames(16'h1 << 7, 3, 0);
        pressed = 16'h1 << 7;
        repeat (5) step(1'b0);
        chk("pre_rst_valid", 32'(o_valid), 32'd1);
        #3;
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge i_clk);
        #1;
        check_reset_outputs("rst_hold");
        i_rst_n = 1'b1;
        model_reset();
        acc_cnt = 0;
        run_frames(16'h1 << 7, 3, 1);
        run_frames(16'h0, 2, 2);
        chk("post_rst_events", 32'(acc_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The block SHALL have parameter SCAN_CYCLES, default 27000, giving clock cycles each column is driven (1 ms at 27 MHz).
REQ-002 The block SHALL have parameter DEBOUNCE_FRAMES, default 4, giving consecutive identical full-matrix frames required before a snapshot is accepted as stable (legal range 1..15).
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 i_rows_neg  input  4  matrix row lines, active-low (pulled up externally), asynchronous to i_clk.
REQ-006 o_cols_neg  output  4  column drive, active-low, exactly one bit low at all times.
REQ-007 o_key  output  4  key code = row*4 + col of the accepted key, held while o_valid=1.
REQ-008 o_valid  output  1  key event pending.
REQ-009 i_ready  input  1  consumer accepts the event when o_valid=1 and i_ready=1 in the same cycle.
REQ-010 o_overrun  output  1  one-cycle pulse when a new event is dropped because o_valid is still 1.

Function
REQ-011 i_rows_neg SHALL pass through a 2-flop synchronizer before any use; the synchronized row value drives sampling.
REQ-012 A dwell counter SHALL count 0..SCAN_CYCLES-1 and wrap; the terminal count is the "tick".
REQ-013 On tick, the synchronized rows SHALL be captured (inverted, 1=pressed) into the 4 frame bits of the currently driven column, then o_cols_neg SHALL rotate left by one (1110 -> 1101 -> 1011 -> 0111 -> 1110).
REQ-014 A frame SHALL complete on the tick sampling column 3; the 16-bit frame (bit index row*4+col) is then compared with the previous frame.
REQ-015 A match counter SHALL increment (saturating at DEBOUNCE_FRAMES) on equal frames and reload to 1 on unequal frames; when it reaches DEBOUNCE_FRAMES the frame SHALL become the stable snapshot.
REQ-016 Key FSM states: IDLE (stable snapshot empty), HELD (exactly one key stable), MULTI (two or more keys stable).
REQ-017 IDLE -> HELD on stable single key SHALL generate a key event for that code; IDLE -> MULTI generates no event.
REQ-018 HELD -> IDLE on stable empty; HELD -> MULTI on stable multi-key; MULTI -> IDLE only on stable empty; MULTI -> HELD and HELD -> HELD (different key) SHALL NOT generate events (release required before next event).
REQ-019 A key event SHALL assert o_valid and load o_key the cycle after the frame-completing tick that established stability.
REQ-020 o_valid and o_key SHALL remain constant until handshake; o_valid deasserts the cycle after o_valid&&i_ready.
REQ-021 An event arriving while o_valid=1 and not being accepted that same cycle SHALL be dropped and o_overrun pulsed for one cycle; o_key unchanged.
REQ-022 An event arriving in the same cycle as an accepting handshake SHALL be loaded (o_valid stays 1, o_key updates, no overrun).
REQ-023 i_ready while o_valid=0 SHALL have no effect.

Reset
REQ-024 While i_rst_n=0: o_cols_neg=1110, o_valid=0, o_key=0, o_overrun=0, dwell counter=0, frame/previous/stable snapshots=0, match counter=0, FSM=IDLE, synchronizer=1111.
REQ-025 Reset asserted mid-frame or with an event pending SHALL discard all state; the first frame after release starts at column 0.

Structure
REQ-026 Key FSM state encoding, the 4x4 matrix dimensions and the column rotation seed (1110) SHALL live in a shared package with the display drivers.
REQ-027 The dwell counter plus column rotator SHALL be one sub-module, scan_strobe, also reusable by the display multiplexer.

Verification
REQ-028 SCAN_CYCLES=4, DEBOUNCE_FRAMES=2, no keys -> o_cols_neg cycles 1110,1101,1011,0111 every 4 clocks; o_valid never asserts.
REQ-029 Key row2/col1 held steady, i_ready=1 -> one o_valid pulse with o_key=9 after the second identical frame; no further events while held; none on release.
REQ-030 Key bounces (toggles every frame) for 3 frames then settles -> exactly one event, o_key=code, issued only after 2 identical frames.
REQ-031 i_ready=0; press/release key 0 then key 5 -> o_valid holds o_key=0; second event drops with one-cycle o_overrun; after i_ready=1, o_valid clears.
REQ-032 Keys 3 and 12 pressed together, then 12 released -> no event (MULTI -> HELD); release all then press 12 -> event o_key=12.
REQ-033 i_rst_n pulsed low mid-frame with o_valid=1 -> outputs immediately at reset values; scan restarts at 1110.
